// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE
  } loader_state_t;

  localparam int HDR_BYTES   = 2;
  localparam int WORD_BYTES  = 4;
  localparam int INSTR_WIDTH = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer; word shows the lanes with the
// current byte already inserted so the writer can latch it same edge.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   load,
  input  logic [7:0]             in_data,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_full
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]       byte_idx;
  logic [INSTR_WIDTH-1:0] lanes;

  always_comb begin
    word = lanes;
    if (load) begin
      word[{byte_idx, 3'b000} +: 8] = in_data;
    end
  end

  assign word_full = load && (byte_idx == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (load) begin
      byte_idx <= byte_idx + IDX_W'(1);
      lanes    <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, then packed words written to
// instruction memory from address 0 while the core is held in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  loader_state_t          state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                   overflow_d;
  logic                   mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_d;
  logic [INSTR_WIDTH-1:0] mem_wdata_d;

  logic                   xfer;
  logic                   in_range;
  logic                   pk_clr;
  logic                   pk_load;
  logic [INSTR_WIDTH-1:0] pk_word;
  logic                   pk_full;

  assign xfer     = in_valid & in_ready;
  assign in_range = 32'(word_idx_q) < DEPTH;
  assign pk_clr   = xfer && (state_q == HDR_HI);
  assign pk_load  = xfer && (state_q == DATA);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .load      (pk_load),
    .in_data   (in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    overflow_d  = overflow;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    unique case (state_q)
      HDR_LO: begin
        if (xfer) begin
          count_d[7:0] = in_data;
          state_d      = HDR_HI;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          count_d    = COUNT_WIDTH'({in_data, count_q[7:0]});
          word_idx_d = '0;
          state_d    = (count_d == '0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (pk_full) begin
          state_d = WRITE;
          // Out-of-range words are consumed but never reach memory.
          if (in_range) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
            mem_wdata_d = pk_word;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + COUNT_WIDTH'(1);
        state_d    = (word_idx_d == count_q) ? DONE : DATA;
      end
      DONE: begin
        if (start) begin
          state_d    = HDR_LO;
          overflow_d = 1'b0;
        end
      end
      default: state_d = HDR_LO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR_LO;
      count_q    <= '0;
      word_idx_q <= '0;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      in_ready   <= (state_d == HDR_LO) || (state_d == HDR_HI) ||
                    (state_d == DATA);
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_hold   <= (state_d != DONE);
      busy       <= (state_d != DONE);
      done       <= (state_d == DONE);
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (DEPTH=4): byte-level reference model compared
// every cycle, plus literal checks on the written memory image.
module tb_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold, busy, done, overflow;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks bytes seen, words finished and the write slot.
  logic [31:0] mem [DEPTH];
  int          we_count = 0;
  int          m_hdr, m_count, m_bytes, m_words;
  bit          m_done, m_wr, m_we, m_ovf;
  logic [31:0] m_addr, m_wdata, m_word;
  bit          xfer_p = 0, start_p = 0;
  logic [7:0]  data_p = 0;

  task automatic model_reset();
    m_hdr = 0; m_count = 0; m_bytes = 0; m_words = 0;
    m_done = 0; m_wr = 0; m_we = 0; m_ovf = 0;
    m_addr = 0; m_wdata = 0; m_word = 0;
  endtask

  task automatic model_step();
    if (m_wr) begin
      m_wr = 0; m_we = 0; m_words++;
      if (m_words == m_count) m_done = 1;
    end else if (m_done) begin
      if (start_p) begin m_done = 0; m_hdr = 0; m_ovf = 0; end
    end else if (xfer_p) begin
      if (m_hdr == 0) begin
        m_count = int'(data_p); m_hdr = 1;
      end else if (m_hdr == 1) begin
        m_count += int'(data_p) * 256; m_hdr = 2;
        m_words = 0; m_bytes = 0;
        if (m_count == 0) m_done = 1;
      end else begin
        m_word[8*m_bytes +: 8] = data_p;
        m_bytes++;
        if (m_bytes == 4) begin
          m_bytes = 0; m_wr = 1;
          if (m_words < DEPTH) begin
            m_we = 1; m_addr = 32'(m_words); m_wdata = m_word;
          end else m_ovf = 1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      else model_step();
      chk("in_ready", 32'(in_ready), 32'(!m_done && !m_wr));
      chk("busy", 32'(busy), 32'(!m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        we_count++;
      end
      xfer_p  = in_valid && in_ready && !reset;
      data_p  = in_data;
      start_p = start;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    bit  got;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) break;
      if (++n > 50) begin
        errors++; checks++;
        $display("FAIL send_byte: timeout on byte %h", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (gaps) tick(1);
      if (gaps && (i == 3 || i == 7)) tick(5);
      if (gaps && i == 4) pulse_start();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (++n > 200) begin
        errors++; checks++;
        $display("FAIL wait_done: timeout, done=%b", done);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hxxxx_xxxx;
  endtask

  logic [7:0] q[$];
  int         base;

  initial begin
    clear_mem();
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);

    // Basic two-word load.
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
          8'h93, 8'h05, 8'hA0, 8'h00};
    send_seq(q, 0);
    wait_done();
    chk("basic writes", 32'(we_count), 32'd2);
    chk("basic mem0", mem[0], 32'h0050_0513);
    chk("basic mem1", mem[1], 32'h00A0_0593);
    chk("basic cpu_hold", 32'(cpu_hold), 32'd0);

    // Re-arm from DONE.
    pulse_start();
    chk("reload cpu_hold", 32'(cpu_hold), 32'd1);
    chk("reload done", 32'(done), 32'd0);

    // Empty program.
    base = we_count;
    q = '{8'h00, 8'h00};
    send_seq(q, 0);
    wait_done();
    chk("empty writes", 32'(we_count - base), 32'd0);
    chk("empty cpu_hold", 32'(cpu_hold), 32'd0);

    // Host gaps, with an ignored start during DATA.
    pulse_start();
    clear_mem();
    base = we_count;
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
          8'h93, 8'h05, 8'hA0, 8'h00};
    send_seq(q, 1);
    wait_done();
    chk("gaps writes", 32'(we_count - base), 32'd2);
    chk("gaps mem0", mem[0], 32'h0050_0513);
    chk("gaps mem1", mem[1], 32'h00A0_0593);

    // count == DEPTH fills memory without overflow.
    pulse_start();
    base = we_count;
    q = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) q.push_back(8'(i + 16));
    send_seq(q, 0);
    wait_done();
    chk("full writes", 32'(we_count - base), 32'd4);
    chk("full mem3", mem[3], 32'h1F1E_1D1C);
    chk("full overflow", 32'(overflow), 32'd0);

    // count == DEPTH+1 suppresses the fifth word.
    pulse_start();
    clear_mem();
    base = we_count;
    q = '{8'h05, 8'h00};
    for (int i = 0; i < 20; i++) q.push_back(8'(i));
    send_seq(q, 0);
    wait_done();
    chk("ovf writes", 32'(we_count - base), 32'd4);
    chk("ovf mem0", mem[0], 32'h0302_0100);
    chk("ovf mem3", mem[3], 32'h0F0E_0D0C);
    chk("ovf flag", 32'(overflow), 32'd1);
    chk("ovf done", 32'(done), 32'd1);
    pulse_start();
    chk("ovf cleared", 32'(overflow), 32'd0);

    // Reset after two bytes of the second word.
    clear_mem();
    base = we_count;
    q = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA, 8'hBB};
    send_seq(q, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    chk("rstmid in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("rstmid writes", 32'(we_count - base), 32'd1);
    chk("rstmid mem0", mem[0], 32'h1122_3344);
    chk("rstmid mem1", mem[1], 32'hxxxx_xxxx);
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(q, 0);
    wait_done();
    chk("fresh mem0", mem[0], 32'hDEAD_BEEF);
    chk("fresh writes", 32'(we_count - base), 32'd2);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
